// File: rtl/vram_pkg.sv
// Shared types and constants for the display RAM.
// No logic; types only.
// No flow control.
package vram_pkg;

   // Width of one byte lane covered by a single write-enable bit.
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } fill_state_t;

endpackage

// File: rtl/vram_fill_ctrl.sv
// Fill engine: sweeps every address with a latched word after reset or on command.
// Latency: busy_o rises one cycle after the start; 2**ADDR_W write cycles plus one DONE cycle.
// Backpressure: none; while busy_o is high the top level blocks port traffic and ignores restarts.
// Ports:
//   clk, rst_ni                 clock, async active-low reset
//   fill_start_i, fill_value_i  command fill and its word (sampled together)
//   busy_o                      high in FILL and DONE
//   fill_we_o/addr_o/data_o     RAM write request owned by the engine
module vram_fill_ctrl
   import vram_pkg::*;
#(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 16,
   parameter int FILL_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_ni,
   input  logic              fill_start_i,
   input  logic [DATA_W-1:0] fill_value_i,
   output logic              busy_o,
   output logic              fill_we_o,
   output logic [ADDR_W-1:0] fill_addr_o,
   output logic [DATA_W-1:0] fill_data_o
);

   fill_state_t       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q;
   logic [DATA_W-1:0] val_q;
   // Armed by reset so the first cycle after deassertion launches a zero fill.
   logic              auto_q;
   logic              start;

   // Restarts are only honoured from IDLE, so a mid-fill pulse cannot extend it.
   assign start = (state_q == IDLE) && (auto_q || fill_start_i);

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (auto_q || fill_start_i) state_d = FILL;
         FILL:    if (&cnt_q)                 state_d = DONE;
         DONE:                                state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != IDLE);
      fill_we_o   = (state_q == FILL);
      fill_addr_o = cnt_q;
      fill_data_o = val_q;
   end

   // Counter wraps to 0 naturally after the last address.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         val_q  <= '0;
         auto_q <= (FILL_ON_RESET != 0);
      end else begin
         auto_q <= 1'b0;
         if (start) begin
            cnt_q <= '0;
            val_q <= auto_q ? '0 : fill_value_i;
         end else if (state_q == FILL) begin
            cnt_q <= cnt_q + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/vram.sv
// Display RAM with byte-enable writes, pipelined reads and a whole-array fill engine.
// Latency: read 1 + OUT_REG cycles, write 1 cycle, fill 2**ADDR_W + 1 busy cycles.
// Backpressure: while busy_o is high, port reads, writes and fill starts are dropped.
// Ports:
//   clk, rst_ni                       clock, async active-low reset
//   rd_en_i, rd_address_i             read request
//   rd_data_o, rd_valid_o             read result (data holds between reads)
//   wr_en_i, wr_be_i, wr_address_i,
//   wr_data_i                         byte-masked write request
//   fill_start_i, fill_value_i        command fill
//   busy_o                            fill in progress
// Build option: define VRAM_RDW_BYPASS_EN to return the merged word on a same-cycle,
// same-address read and write; otherwise the read returns the old word.
module vram
   import vram_pkg::*;
#(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 16,
   parameter int OUT_REG       = 1,
   parameter int FILL_ON_RESET = 1
) (
   input  logic                     clk,
   input  logic                     rst_ni,
   input  logic                     rd_en_i,
   input  logic [ADDR_W-1:0]        rd_address_i,
   output logic [DATA_W-1:0]        rd_data_o,
   output logic                     rd_valid_o,
   input  logic                     wr_en_i,
   input  logic [DATA_W/BYTE_W-1:0] wr_be_i,
   input  logic [ADDR_W-1:0]        wr_address_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     fill_start_i,
   input  logic [DATA_W-1:0]        fill_value_i,
   output logic                     busy_o
);

   localparam int NB    = DATA_W / BYTE_W;
   localparam int DEPTH = 2 ** ADDR_W;

   if ((DATA_W % BYTE_W) != 0 || DATA_W < BYTE_W) begin : g_bad_data_w
      $error("vram: DATA_W must be a non-zero multiple of 8");
   end

   logic              busy;
   logic              fill_we;
   logic [ADDR_W-1:0] fill_addr;
   logic [DATA_W-1:0] fill_data;
   logic              rd_acc;
   logic              wr_acc;

   vram_fill_ctrl #(
      .ADDR_W        (ADDR_W),
      .DATA_W        (DATA_W),
      .FILL_ON_RESET (FILL_ON_RESET)
   ) u_fill_ctrl (
      .clk          (clk),
      .rst_ni       (rst_ni),
      .fill_start_i (fill_start_i),
      .fill_value_i (fill_value_i),
      .busy_o       (busy),
      .fill_we_o    (fill_we),
      .fill_addr_o  (fill_addr),
      .fill_data_o  (fill_data)
   );

   assign busy_o = busy;
   assign rd_acc = rd_en_i & ~busy;
   assign wr_acc = wr_en_i & ~busy;

   // Storage: unreset so it maps onto block RAM. The engine owns the write port
   // while busy, which is exactly when port writes are blocked.
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[fill_addr] <= fill_data;
      end else if (wr_acc) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be_i[k]) begin
               mem[wr_address_i][k*BYTE_W +: BYTE_W] <= wr_data_i[k*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Read stage 1: registered RAM output, read-first. Only loads on an accepted
   // read so the last result is held.
   logic [DATA_W-1:0] ram_q;
   logic              rd_vld_q;
   logic [DATA_W-1:0] s1_data;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         ram_q    <= '0;
         rd_vld_q <= 1'b0;
      end else begin
         rd_vld_q <= rd_acc;
         if (rd_acc) begin
            ram_q <= mem[rd_address_i];
         end
      end
   end

`ifdef VRAM_RDW_BYPASS_EN
   // Capture the colliding write's lanes beside the read and merge them after the
   // RAM register, keeping the array itself a plain read-first memory.
   logic [NB-1:0]     byp_be_q;
   logic [DATA_W-1:0] byp_dat_q;

   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         byp_be_q  <= '0;
         byp_dat_q <= '0;
      end else if (rd_acc) begin
         byp_be_q  <= (wr_acc && (wr_address_i == rd_address_i)) ? wr_be_i : '0;
         byp_dat_q <= wr_data_i;
      end
   end

   always_comb begin
      s1_data = ram_q;
      for (int k = 0; k < NB; k++) begin
         if (byp_be_q[k]) begin
            s1_data[k*BYTE_W +: BYTE_W] = byp_dat_q[k*BYTE_W +: BYTE_W];
         end
      end
   end
`else
   assign s1_data = ram_q;
`endif

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] out_q;
      logic              out_vld_q;

      always_ff @(posedge clk or negedge rst_ni) begin
         if (!rst_ni) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
         end else begin
            out_vld_q <= rd_vld_q;
            if (rd_vld_q) begin
               out_q <= s1_data;
            end
         end
      end

      assign rd_data_o  = out_q;
      assign rd_valid_o = out_vld_q;
   end else begin : g_no_out_reg
      assign rd_data_o  = s1_data;
      assign rd_valid_o = rd_vld_q;
   end

endmodule
